// File: rtl/fp_add_normalizer.sv
// Post-adder normalise/round/pack stage of the single-precision add path, REQ/ACK handshake.
// Build option: FP_NORM_ROUND_NEAREST_EN selects round-to-nearest-even; default build truncates.
module fp_add_normalizer #(
   parameter int unsigned MANT_W = 24,
   parameter int unsigned EXP_W  = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ,
   input  logic [MANT_W-1:0] SUM,
   input  logic              COUT,
   input  logic [2:0]        GRS,
   input  logic [EXP_W-1:0]  EXP_IN,
   input  logic              SIGN_IN,
   output logic              ACK,
   output logic [31:0]       DATAOUT,
   output logic [2:0]        EXC,
   output logic              BUSY
);
   localparam int unsigned XEXP_W = EXP_W + 1;
   localparam int unsigned CNT_W  = $clog2(MANT_W);
   localparam logic [XEXP_W-1:0] EXP_MAX    = XEXP_W'((1 << EXP_W) - 1);
   localparam logic [CNT_W-1:0]  MAX_SHIFTS = CNT_W'(MANT_W - 1);
   localparam logic [MANT_W-1:0] MANT_ONE   = {1'b1, {(MANT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   state_t            state, state_nxt;
   logic [MANT_W-1:0] mant, mant_nxt;
   logic [XEXP_W-1:0] exp_r, exp_nxt;
   logic              sign, sign_nxt;
   logic              g, g_nxt, r, r_nxt, s, s_nxt;
   logic              denorm, denorm_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [31:0]       dataout_nxt;
   logic [2:0]        exc_nxt;
   logic              ack_nxt, busy_nxt;
   logic              round_up;
   logic [MANT_W:0]   mant_rnd;
   logic [MANT_W-1:0] mant_fin;
   logic [XEXP_W-1:0] exp_fin;
   logic              denorm_fin;

`ifdef FP_NORM_ROUND_NEAREST_EN
   assign round_up = g & (r | s | mant[0]);
`else
   logic unused_sticky;
   assign round_up      = 1'b0;
   assign unused_sticky = s;
`endif

   // Next-state, datapath and registered-output values
   always_comb begin
      state_nxt   = state;
      mant_nxt    = mant;
      exp_nxt     = exp_r;
      sign_nxt    = sign;
      g_nxt       = g;
      r_nxt       = r;
      s_nxt       = s;
      denorm_nxt  = denorm;
      cnt_nxt     = cnt;
      dataout_nxt = DATAOUT;
      exc_nxt     = EXC;

      mant_rnd   = {1'b0, mant} + (MANT_W+1)'(round_up);
      mant_fin   = mant_rnd[MANT_W-1:0];
      exp_fin    = exp_r;
      denorm_fin = denorm;
      if (mant_rnd[MANT_W]) begin
         mant_fin = MANT_ONE;
         exp_fin  = exp_r + XEXP_W'(1);
      end else if (denorm && mant_rnd[MANT_W-1]) begin
         exp_fin    = XEXP_W'(1);
         denorm_fin = 1'b0;
      end

      case (state)
         IDLE: begin
            if (REQ) begin
               sign_nxt   = SIGN_IN;
               denorm_nxt = 1'b0;
               cnt_nxt    = '0;
               if (COUT) begin
                  mant_nxt  = {1'b1, SUM[MANT_W-1:1]};
                  g_nxt     = SUM[0];
                  r_nxt     = GRS[2];
                  s_nxt     = GRS[1] | GRS[0];
                  exp_nxt   = XEXP_W'(EXP_IN) + XEXP_W'(1);
                  state_nxt = ROUND;
               end else begin
                  mant_nxt = SUM;
                  g_nxt    = GRS[2];
                  r_nxt    = GRS[1];
                  s_nxt    = GRS[0];
                  exp_nxt  = XEXP_W'(EXP_IN);
                  if (SUM == '0 && GRS == 3'b000) begin
                     dataout_nxt = {SIGN_IN, 31'b0};
                     exc_nxt     = 3'b001;
                     state_nxt   = DONE;
                  end else if (EXP_IN == '1) begin
                     dataout_nxt = {SIGN_IN, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
                     exc_nxt     = 3'b010;
                     state_nxt   = DONE;
                  end else if (SUM[MANT_W-1]) begin
                     state_nxt = ROUND;
                  end else begin
                     state_nxt = SHIFT;
                  end
               end
            end
         end
         SHIFT: begin
            if (mant[MANT_W-1] || cnt == MAX_SHIFTS) begin
               state_nxt = ROUND;
            end else if (exp_r <= XEXP_W'(1)) begin
               denorm_nxt = 1'b1;
               exp_nxt    = '0;
               state_nxt  = ROUND;
            end else begin
               // Leave as soon as the shifted-in value is normalised so n shifts cost n cycles
               mant_nxt = {mant[MANT_W-2:0], g};
               g_nxt    = r;
               r_nxt    = 1'b0;
               exp_nxt  = exp_r - XEXP_W'(1);
               cnt_nxt  = cnt + CNT_W'(1);
               if (mant[MANT_W-2]) state_nxt = ROUND;
            end
         end
         ROUND: begin
            if (exp_fin >= EXP_MAX) begin
               dataout_nxt = {sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
               exc_nxt     = 3'b010;
            end else begin
               dataout_nxt = {sign, exp_fin[EXP_W-1:0], mant_fin[MANT_W-2:0]};
               exc_nxt     = {denorm_fin, 1'b0, (mant_fin == '0)};
            end
            state_nxt = DONE;
         end
         DONE: begin
            if (!REQ) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      ack_nxt  = (state_nxt == DONE);
      busy_nxt = (state_nxt != IDLE);
   end

   // State, datapath and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         mant    <= '0;
         exp_r   <= '0;
         sign    <= 1'b0;
         g       <= 1'b0;
         r       <= 1'b0;
         s       <= 1'b0;
         denorm  <= 1'b0;
         cnt     <= '0;
         ACK     <= 1'b0;
         BUSY    <= 1'b0;
         DATAOUT <= '0;
         EXC     <= '0;
      end else begin
         state   <= state_nxt;
         mant    <= mant_nxt;
         exp_r   <= exp_nxt;
         sign    <= sign_nxt;
         g       <= g_nxt;
         r       <= r_nxt;
         s       <= s_nxt;
         denorm  <= denorm_nxt;
         cnt     <= cnt_nxt;
         ACK     <= ack_nxt;
         BUSY    <= busy_nxt;
         DATAOUT <= dataout_nxt;
         EXC     <= exc_nxt;
      end
   end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed, table-driven bench for fp_add_normalizer plus reset and early-REQ-drop sequences.
module tb_fp_add_normalizer;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REQ = 1'b0;
   logic [23:0] SUM = '0;
   logic        COUT = 1'b0;
   logic [2:0]  GRS = '0;
   logic [7:0]  EXP_IN = '0;
   logic        SIGN_IN = 1'b0;
   logic        ACK;
   logic [31:0] DATAOUT;
   logic [2:0]  EXC;
   logic        BUSY;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [23:0] sum;
      logic        cout;
      logic [2:0]  grs;
      logic [7:0]  exp_in;
      logic        sign_in;
      logic [31:0] dout;
      logic [2:0]  exc;
      int          lat;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   fp_add_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .SUM(SUM), .COUT(COUT), .GRS(GRS),
      .EXP_IN(EXP_IN), .SIGN_IN(SIGN_IN), .ACK(ACK), .DATAOUT(DATAOUT),
      .EXC(EXC), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      SUM = v.sum; COUT = v.cout; GRS = v.grs; EXP_IN = v.exp_in; SIGN_IN = v.sign_in;
   endtask

   // Full handshake for one vector; inputs are scrambled after capture to prove they were latched
   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      logic seen;
      @(negedge CLK);
      drive(v);
      REQ = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      SUM = ~v.sum; COUT = ~v.cout; GRS = ~v.grs; EXP_IN = ~v.exp_in; SIGN_IN = ~v.sign_in;
      lat  = 1;
      seen = ACK;
      while (!seen && lat < 64) begin
         @(negedge CLK);
         lat++;
         seen = ACK;
      end
      check($sformatf("v%0d ack_seen", idx), 32'(seen), 32'd1);
      check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d dataout", idx), DATAOUT, v.dout);
      check($sformatf("v%0d exc", idx), 32'(EXC), 32'(v.exc));
      check($sformatf("v%0d busy_done", idx), 32'(BUSY), 32'd1);
      REQ = 1'b0;
      @(negedge CLK);
      check($sformatf("v%0d ack_drop", idx), 32'(ACK), 32'd0);
      check($sformatf("v%0d busy_idle", idx), 32'(BUSY), 32'd0);
      check($sformatf("v%0d dataout_hold", idx), DATAOUT, v.dout);
   endtask

   initial begin
      //            sum        cout  grs     exp    sign  dout           exc     lat
      vecs[0]  = '{24'h000000, 1'b1, 3'b000, 8'd127, 1'b0, 32'h40000000, 3'b000, 2};
      vecs[1]  = '{24'h400000, 1'b0, 3'b000, 8'd130, 1'b0, 32'h40800000, 3'b000, 3};
      vecs[2]  = '{24'h000000, 1'b0, 3'b000, 8'd77,  1'b1, 32'h80000000, 3'b001, 1};
      vecs[3]  = '{24'h800000, 1'b1, 3'b000, 8'd254, 1'b0, 32'h7F800000, 3'b010, 2};
      vecs[4]  = '{24'h000001, 1'b0, 3'b000, 8'd3,   1'b0, 32'h00000004, 3'b100, 5};
      vecs[5]  = '{24'h123456, 1'b0, 3'b000, 8'd255, 1'b1, 32'hFF800000, 3'b010, 1};
      vecs[6]  = '{24'h000100, 1'b0, 3'b110, 8'd100, 1'b0, 32'h2A806000, 3'b000, 17};
      vecs[7]  = '{24'h800000, 1'b0, 3'b000, 8'd1,   1'b1, 32'h80800000, 3'b000, 2};
`ifdef FP_NORM_ROUND_NEAREST_EN
      vecs[8]  = '{24'hFFFFFF, 1'b0, 3'b100, 8'd127, 1'b0, 32'h40000000, 3'b000, 2};
      vecs[9]  = '{24'h000003, 1'b1, 3'b000, 8'd127, 1'b0, 32'h40000002, 3'b000, 2};
      vecs[10] = '{24'h3FFFFF, 1'b0, 3'b110, 8'd2,   1'b0, 32'h00800000, 3'b000, 4};
`else
      vecs[8]  = '{24'hFFFFFF, 1'b0, 3'b100, 8'd127, 1'b0, 32'h3FFFFFFF, 3'b000, 2};
      vecs[9]  = '{24'h000003, 1'b1, 3'b000, 8'd127, 1'b0, 32'h40000001, 3'b000, 2};
      vecs[10] = '{24'h3FFFFF, 1'b0, 3'b110, 8'd2,   1'b0, 32'h007FFFFF, 3'b100, 4};
`endif

      repeat (3) @(negedge CLK);
      check("reset ack", 32'(ACK), 32'd0);
      check("reset busy", 32'(BUSY), 32'd0);
      check("reset dataout", DATAOUT, 32'd0);
      check("reset exc", 32'(EXC), 32'd0);
      RST = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // REQ dropped while still in ROUND: ACK must still pulse for one cycle
      @(negedge CLK);
      drive(vecs[0]);
      REQ = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      REQ = 1'b0;
      check("early ack_pre", 32'(ACK), 32'd0);
      @(negedge CLK);
      check("early ack_pulse", 32'(ACK), 32'd1);
      check("early dataout", DATAOUT, 32'h40000000);
      @(negedge CLK);
      check("early ack_drop", 32'(ACK), 32'd0);
      check("early busy", 32'(BUSY), 32'd0);

      // Reset in the middle of a long shift sequence aborts the result
      @(negedge CLK);
      drive(vecs[6]);
      REQ = 1'b1;
      @(posedge CLK);
      repeat (3) @(negedge CLK);
      check("midshift busy", 32'(BUSY), 32'd1);
      check("midshift ack", 32'(ACK), 32'd0);
      RST = 1'b1;
      REQ = 1'b0;
      @(negedge CLK);
      check("midrst ack", 32'(ACK), 32'd0);
      check("midrst busy", 32'(BUSY), 32'd0);
      check("midrst dataout", DATAOUT, 32'd0);
      check("midrst exc", 32'(EXC), 32'd0);
      RST = 1'b0;
      run_vec(vecs[1], 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_add_normalizer.md
Name: fp_add_normalizer

Overview:
- Post-adder stage of the FPU single-precision add path.
- Consumes the 24-bit mantissa sum, its carry-out, the common (larger) biased exponent and the result sign.
- Normalises the result iteratively, one left shift per cycle, then optionally rounds.
- Packs an IEEE-754 single word and reports exceptions over a 4-phase REQ/ACK handshake to the add controller.

Parameters:
- MANT_W, 24, mantissa width including hidden bit
- EXP_W, 8, biased exponent width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- REQ  in  1  request; upstream holds high with stable data until ACK, then drops
- SUM  in  MANT_W  mantissa sum from adder
- COUT  in  1  adder carry-out
- GRS  in  3  guard/round/sticky bits from alignment, [2]=G
- EXP_IN  in  EXP_W  common biased exponent
- SIGN_IN  in  1  result sign
- ACK  out  1  result valid; held until REQ sampled low
- DATAOUT  out  32  packed {sign, exp[7:0], frac[22:0]}
- EXC  out  3  [0] zero, [1] overflow, [2] underflow/denormal
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-operation aborts; the in-flight result is discarded.
- Internal registers: mant (MANT_W), exp (EXP_W+1, unsigned), sign, g, r, s.
- States: IDLE, SHIFT, ROUND, DONE.
- IDLE, with REQ=1, captures the inputs, then branches:
  - COUT=1: mant={1,SUM[23:1]}; g=SUM[0]; r=GRS[2]; s=GRS[1]|GRS[0]; exp=EXP_IN+1; go to ROUND.
  - COUT=0, SUM=0, GRS=0: go to DONE with DATAOUT={SIGN_IN,31'b0} and EXC=3'b001.
  - EXP_IN=255: go to DONE with DATAOUT={SIGN_IN,8'hFF,23'b0} and EXC=3'b010.
  - SUM[23]=1: go to ROUND.
  - Otherwise: go to SHIFT.
- SHIFT, evaluated each cycle:
  - If mant[23]=1: go to ROUND.
  - Else if exp<=1: set denormal flag, force exp=0, go to ROUND.
  - Else: mant={mant[22:0],g}; g=r; r=0; exp=exp-1.
  - At most 23 shift cycles.
- ROUND:
  - Rounding per the optional feature.
  - If rounding carries out of mant, set mant=24'h800000 and exp+1. A denormal that rounds up to 24'h800000 becomes exp=1 and clears the denormal flag.
  - If exp>=255: DATAOUT={sign,8'hFF,23'b0}, EXC=3'b010.
  - Else: DATAOUT={sign,exp[7:0],mant[22:0]}; EXC[2]=denormal flag; EXC[0]=1 if mant=0.
  - Go to DONE.
- DONE:
  - ACK=1; DATAOUT and EXC are stable.
  - When REQ is sampled 0: ACK=0, go to IDLE.
  - ACK is always high for at least one cycle, even if REQ dropped early.
- Outputs are registered; DATAOUT and EXC hold their last value while in IDLE.
- Latency, counted from the capture edge to ACK high:
  - Zero or special: 1 cycle.
  - Normalised or carry-out: 2 cycles.
  - n left shifts: 2+n cycles.
- REQ is ignored outside IDLE, and a new request is not accepted in the cycle that DONE exits.

Optional Feature:
- Macro: FP_NORM_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even in ROUND; increment mant when g&(r|s|mant[0]).
- Undefined: truncation; g, r and s are ignored in ROUND, and ROUND costs the same single cycle.

Test Plan:
- COUT=1, SUM=24'h000000, EXP_IN=127, SIGN_IN=0 -> DATAOUT=32'h40000000, EXC=0, ACK 2 cycles after capture.
- COUT=0, SUM=24'h400000, EXP_IN=130 -> one shift, DATAOUT=32'h40800000, EXC=0, ACK 3 cycles after capture.
- COUT=0, SUM=0, GRS=0, SIGN_IN=1 -> DATAOUT=32'h80000000, EXC=3'b001, ACK 1 cycle after capture.
- COUT=1, SUM=24'h800000, EXP_IN=254 -> DATAOUT=32'h7F800000, EXC=3'b010.
- COUT=0, SUM=24'h000001, EXP_IN=3, GRS=0 -> two shifts, DATAOUT=32'h00000004, EXC=3'b100.
- SUM=24'hFFFFFF, COUT=0, GRS=3'b100, EXP_IN=127:
  - With the macro: 32'h40000000.
  - Without the macro: 32'h3FFFFFFF.
- Reset asserted mid-SHIFT -> next cycle ACK=0, BUSY=0, DATAOUT=0, EXC=0; a fresh request then completes normally.
